// File: rtl/pic_ctrl.sv
// pic_ctrl: 8-line priority interrupt controller (edge-triggered IRR, IMR/ISR, 3-state INTA vector sequencer, port reads).
// Optional auto-EOI on the vector cycle is compiled in with macro PIC_CTRL_AEOI_EN.
module pic_ctrl (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iIrq,
  input  logic       iIoWr,
  input  logic       iIoRd,
  input  logic       iIoA0,
  input  logic [7:0] iIoData,
  input  logic       iIntAck,
  output logic       oInt,
  output logic       oSel,
  output logic [7:0] oData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_ACK2 = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_irq_q;
  logic       r_edge_en;
  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_imr;
  logic [4:0] r_vb;
  logic       r_rsel_isr;
  logic       r_armed;
  logic [2:0] r_lvl;
  logic       r_spur;
  logic       r_ack1_first;
  logic       r_int;
  logic       r_sel;
  logic [7:0] r_data;
`ifdef PIC_CTRL_AEOI_EN
  logic       r_aeoi;
`endif

  logic [7:0] w_edge;
  logic [7:0] w_active;
  logic [3:0] w_cand;
  logic [3:0] w_isr_hi;
  logic       w_int_cond;
  logic       w_wr_icw1;
  logic       w_wr_icw2;
  logic       w_wr_ocw1;
  logic       w_wr_ocw2;
  logic       w_wr_ocw3;
  logic [7:0] w_eoi_clr;
  logic [7:0] w_ack_mask;
  logic       w_ack1_do;
  logic [7:0] w_set_mask;
  logic [7:0] w_irr_nxt;
  logic [7:0] w_isr_nxt;
  logic [7:0] w_rd_val;

  // Lowest set bit index; bit 3 of the result flags an empty vector.
  function automatic logic [3:0] f_lowest(input logic [7:0] v);
    logic [3:0] res;
    res = 4'h8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) res = {1'b0, 3'(i)};
    end
    return res;
  endfunction

  // Edge detection is held off for the first clock after reset so lines already high are not seen as new.
  assign w_edge     = r_edge_en ? (iIrq & ~r_irq_q) : 8'h00;
  assign w_active   = r_irr & ~r_imr;
  assign w_cand     = f_lowest(w_active);
  assign w_isr_hi   = f_lowest(r_isr);
  assign w_int_cond = !w_cand[3] && (w_isr_hi[3] || (w_cand[2:0] < w_isr_hi[2:0]));

  assign w_wr_icw1 = iIoWr && !iIoA0 && iIoData[4];
  assign w_wr_icw2 = iIoWr && iIoA0 && r_armed;
  assign w_wr_ocw1 = iIoWr && iIoA0 && !r_armed;
  assign w_wr_ocw2 = iIoWr && !iIoA0 && !iIoData[4] && !iIoData[3];
  assign w_wr_ocw3 = iIoWr && !iIoA0 && !iIoData[4] && iIoData[3];

  assign w_ack_mask = 8'h01 << r_lvl;
  assign w_ack1_do  = (r_state == S_ACK1) && r_ack1_first && !r_spur;
  assign w_set_mask = w_ack1_do ? w_ack_mask : 8'h00;

  always_comb begin
    w_eoi_clr = 8'h00;
    if (w_wr_ocw2) begin
      if (iIoData[7:5] == 3'b001 && !w_isr_hi[3]) begin
        w_eoi_clr = 8'h01 << w_isr_hi[2:0];
      end else if (iIoData[7:5] == 3'b011) begin
        w_eoi_clr = 8'h01 << iIoData[2:0];
      end
    end
  end

  // EOI/ICW1 clears are applied before the ACK1 set so a same-cycle set survives.
  always_comb begin
    w_isr_nxt = w_wr_icw1 ? 8'h00 : (r_isr & ~w_eoi_clr);
    w_isr_nxt = w_isr_nxt | w_set_mask;
`ifdef PIC_CTRL_AEOI_EN
    if ((r_state == S_ACK2) && r_aeoi && !r_spur) begin
      w_isr_nxt = w_isr_nxt & ~w_ack_mask;
    end
`endif
  end

  assign w_irr_nxt = (r_irr & ~w_set_mask) | w_edge;
  assign w_rd_val  = iIoA0 ? r_imr : (r_rsel_isr ? r_isr : r_irr);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_irq_q    <= 8'h00;
      r_edge_en  <= 1'b0;
      r_irr      <= 8'h00;
      r_isr      <= 8'h00;
      r_imr      <= 8'hFF;
      r_vb       <= 5'b00001;
      r_rsel_isr <= 1'b0;
      r_armed    <= 1'b0;
`ifdef PIC_CTRL_AEOI_EN
      r_aeoi     <= 1'b0;
`endif
    end else begin
      r_irq_q   <= iIrq;
      r_edge_en <= 1'b1;
      r_irr     <= w_irr_nxt;
      r_isr     <= w_isr_nxt;
      if (w_wr_icw1) begin
        r_imr   <= 8'h00;
        r_armed <= 1'b1;
`ifdef PIC_CTRL_AEOI_EN
        r_aeoi  <= iIoData[1];
`endif
      end
      if (w_wr_icw2) begin
        r_vb    <= iIoData[7:3];
        r_armed <= 1'b0;
      end
      if (w_wr_ocw1) begin
        r_imr <= iIoData;
      end
      if (w_wr_ocw3 && iIoData[1]) begin
        r_rsel_isr <= iIoData[0];
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_lvl        <= 3'd0;
      r_spur       <= 1'b0;
      r_ack1_first <= 1'b0;
      r_int        <= 1'b0;
      r_sel        <= 1'b0;
      r_data       <= 8'h00;
    end else begin
      r_ack1_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iIntAck) begin
            r_state      <= S_ACK1;
            r_lvl        <= w_cand[3] ? 3'd7 : w_cand[2:0];
            r_spur       <= w_cand[3];
            r_ack1_first <= 1'b1;
          end
        end
        S_ACK1: begin
          if (iIntAck) r_state <= S_ACK2;
        end
        S_ACK2: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      r_int <= (r_state == S_IDLE) && !iIntAck && w_int_cond;

      // The vector strobe takes the output slot; a colliding read is dropped.
      r_sel <= 1'b0;
      if (r_state == S_ACK2) begin
        r_sel  <= 1'b1;
        r_data <= {r_vb, r_lvl};
      end else if (iIoRd) begin
        r_sel  <= 1'b1;
        r_data <= w_rd_val;
      end
    end
  end

  assign oInt  = r_int;
  assign oSel  = r_sel;
  assign oData = r_data;

endmodule
